// File: rtl/wisc_pkg.sv
// Shared WISC opcode and condition-code encodings, plus the per-opcode flag write mask.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  // Mask bit order matches the flag register: {Z, V, N}
  function automatic logic [2:0] writes_flags(input logic [3:0] opcode);
    logic [2:0] mask;
    case (opcode)
      OP_ADD, OP_SUB:                  mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR:  mask = 3'b100;
      OP_RED, OP_PADDSB, OP_LW, OP_SW,
      OP_LLB, OP_LHB, OP_B, OP_BR,
      OP_PCS, OP_HLT:                  mask = 3'b000;
      default:                         mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch condition evaluator: (Z, V, N, ccc) -> taken.
// Shared with the BR target mux, so it holds no state.
module flag_cond_eval
  import wisc_pkg::*;
(
  input  logic       z,
  input  logic       v,
  input  logic       n,
  input  logic [2:0] ccc,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register and registered branch resolution.
// Optional FLAG_BYPASS_EN forwards same-cycle ALU flags instead of raising br_hazard.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int         NUM_CC   = 8,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [3:0]                ex_opcode,
  input  logic                      Z_set,
  input  logic                      V_set,
  input  logic                      N_set,
  input  logic                      br_valid,
  input  logic [$clog2(NUM_CC)-1:0] br_ccc,
  output logic                      Z,
  output logic                      V,
  output logic                      N,
  output logic                      br_done,
  output logic                      br_taken,
  output logic                      br_hazard
);

  logic [2:0] flags_q;
  logic [2:0] alu_flags;
  logic [2:0] wr_mask;
  logic [2:0] eval_flags;
  logic       cond_taken;
  logic       br_accept;
  logic       br_done_q;
  logic       br_taken_q;

  assign alu_flags = {Z_set, V_set, N_set};

  // A flushed instruction never writes, so the mask already folds in flush
  always_comb begin
    wr_mask = 3'b000;
    if (ex_valid && !flush)
      wr_mask = writes_flags(ex_opcode);
  end

`ifdef FLAG_BYPASS_EN
  assign eval_flags = (wr_mask & alu_flags) | (~wr_mask & flags_q);
  assign br_hazard  = 1'b0;
`else
  assign eval_flags = flags_q;
  assign br_hazard  = br_valid & (|wr_mask);
`endif

  assign br_accept = br_valid & ~stall & ~flush & ~br_hazard;

  flag_cond_eval u_cond (
    .z     (eval_flags[2]),
    .v     (eval_flags[1]),
    .n     (eval_flags[0]),
    .ccc   (br_ccc),
    .taken (cond_taken)
  );

  // Stall freezes every register, including a pending br_done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= FLAG_RST;
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else if (!stall) begin
      flags_q    <= (wr_mask & alu_flags) | (~wr_mask & flags_q);
      br_done_q  <= br_accept;
      br_taken_q <= br_accept & cond_taken;
    end
  end

  assign Z        = flags_q[2];
  assign V        = flags_q[1];
  assign N        = flags_q[0];
  assign br_done  = br_done_q;
  assign br_taken = br_taken_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the flag/branch rules.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flush, ex_valid;
  logic [3:0] ex_opcode;
  logic       Z_set, V_set, N_set;
  logic       br_valid;
  logic [2:0] br_ccc;
  logic       Z, V, N, br_done, br_taken, br_hazard;

  int checks   = 0;
  int failures = 0;

  // Model state: architectural flags and the last resolution
  logic mZ, mV, mN, mDone, mTaken;

  flag_branch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .Z_set     (Z_set),
    .V_set     (V_set),
    .N_set     (N_set),
    .br_valid  (br_valid),
    .br_ccc    (br_ccc),
    .Z         (Z),
    .V         (V),
    .N         (N),
    .br_done   (br_done),
    .br_taken  (br_taken),
    .br_hazard (br_hazard)
  );

  always #5 clk = ~clk;

  function automatic logic condHolds(input logic [2:0] cc, input logic z, input logic v, input logic n);
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic writesZ(input logic [3:0] op);
    return op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6;
  endfunction

  function automatic logic writesVN(input logic [3:0] op);
    return op == 4'h0 || op == 4'h1;
  endfunction

  function automatic logic modelHazard();
`ifdef FLAG_BYPASS_EN
    return 1'b0;
`else
    return br_valid && ex_valid && !flush && writesZ(ex_opcode);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    logic doZ, doVN, ez, ev, en, accept;
    if (rst) begin
      mZ = 1'b0; mV = 1'b0; mN = 1'b0;
      mDone = 1'b0; mTaken = 1'b0;
    end else if (!stall) begin
      doZ  = ex_valid && !flush && writesZ(ex_opcode);
      doVN = ex_valid && !flush && writesVN(ex_opcode);
`ifdef FLAG_BYPASS_EN
      ez = doZ  ? Z_set : mZ;
      ev = doVN ? V_set : mV;
      en = doVN ? N_set : mN;
`else
      ez = mZ; ev = mV; en = mN;
`endif
      accept = br_valid && !flush && !modelHazard();
      mDone  = accept;
      mTaken = accept && condHolds(br_ccc, ez, ev, en);
      if (doZ)  mZ = Z_set;
      if (doVN) begin mV = V_set; mN = N_set; end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    checkOutput("Z", Z, mZ);
    checkOutput("V", V, mV);
    checkOutput("N", N, mN);
    checkOutput("br_done", br_done, mDone);
    if (mDone)
      checkOutput("br_taken", br_taken, mTaken);
    checkOutput("br_hazard", br_hazard, modelHazard());
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic zs, input logic vs,
                               input logic ns, input logic bv, input logic [2:0] cc,
                               input logic st, input logic fl);
    ex_valid = v; ex_opcode = op; Z_set = zs; V_set = vs; N_set = ns;
    br_valid = bv; br_ccc = cc; stall = st; flush = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string name, input logic [2:0] zvn);
    checkOutput({name, "_Z"}, Z, zvn[2]);
    checkOutput({name, "_V"}, V, zvn[1]);
    checkOutput({name, "_N"}, N, zvn[0]);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12 rst = 1'b0;
    checkFlags("reset", 3'b000);
    checkOutput("reset_done", br_done, 1'b0);
    checkOutput("reset_taken", br_taken, 1'b0);

    // ADD then XOR: XOR only touches Z
    tick();
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkFlags("add", 3'b011);
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkFlags("xor", 3'b111);

    // Clear flags, then GT / LE / UN
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkFlags("clear", 3'b000);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    checkOutput("gt_done", br_done, 1'b1);
    checkOutput("gt_taken", br_taken, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    tick();
    checkOutput("le_done", br_done, 1'b1);
    checkOutput("le_taken", br_taken, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    tick();
    checkOutput("un_taken", br_taken, 1'b1);

    // SUB setting Z with a same-cycle EQ branch
    applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    #1;
`ifdef FLAG_BYPASS_EN
    checkOutput("sub_hazard", br_hazard, 1'b0);
`else
    checkOutput("sub_hazard", br_hazard, 1'b1);
`endif
    tick();
`ifdef FLAG_BYPASS_EN
    checkOutput("sub_done", br_done, 1'b1);
    checkOutput("sub_taken", br_taken, 1'b1);
`else
    checkOutput("sub_done", br_done, 1'b0);
`endif
    checkFlags("sub", 3'b100);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    checkOutput("eq_done", br_done, 1'b1);
    checkOutput("eq_taken", br_taken, 1'b1);

    // Reset, then non-flag-writing opcodes
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    applyStimulus(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkFlags("nowrite", 3'b000);

    // Flushed ADD, then a stalled branch
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1);
    tick();
    checkFlags("flush", 3'b000);
    checkOutput("flush_done", br_done, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_done", br_done, 1'b0);
      checkFlags("stall", 3'b000);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    tick();
    checkOutput("unstall_done", br_done, 1'b1);
    checkOutput("unstall_taken", br_taken, 1'b1);

    // Mid-cycle reset drops a pending branch
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkFlags("preset", 3'b111);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 checkFlags("midrst", 3'b000);
    tick();
    idle();
    rst = 1'b0;
    tick();
    checkOutput("postrst_done", br_done, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      tick();
    end
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
